// File: rtl/joybus_reply_tx.sv
// joybus_reply_tx: streams a 1..MAX_BYTES byte reply from an external buffer onto
// the N64 Joybus line. Each bit is four line cells, followed by a controller stop bit.
module joybus_reply_tx #(
  parameter int unsigned CLK_DIV   = 47,
  parameter int unsigned MAX_BYTES = 33,
  parameter int unsigned LEN_W     = $clog2(MAX_BYTES + 1),
  parameter int unsigned ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              drive_low,
  output logic              busy,
  output logic              done,
  output logic              len_err
);

  localparam int unsigned       DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_STOP
  } state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_cell;
  logic [2:0]          r_bit;
  logic [ADDR_W-1:0]   r_byte;
  logic [LEN_W-1:0]    r_len;
  logic [7:0]          r_shift;
  logic [7:0]          r_hold;
  logic                r_pend;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_drive_low;
  logic                r_busy;
  logic                r_done;
  logic                r_len_err;

  logic                w_len_ok;
  logic                w_more_bytes;
  logic [ADDR_W-1:0]   w_next_addr;

  // Start qualification and byte-position helpers
  assign w_len_ok     = (len != '0) && (len <= LEN_MAX);
  assign w_next_addr  = r_byte + ADDR_W'(1);
  assign w_more_bytes = (LEN_W'(r_byte) + LEN_W'(1)) < r_len;

  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign drive_low = r_drive_low;
  assign busy      = r_busy;
  assign done      = r_done;
  assign len_err   = r_len_err;

  // Frame sequencer: fetch, cell timing, bit/byte shifting, prefetch and stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_cell      <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_len       <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_pend      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_drive_low <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_done    <= 1'b0;
      r_len_err <= 1'b0;
      // read data arrives one cycle after the strobe
      r_pend    <= r_rd_en;
      if (r_pend) r_hold <= rd_data;

      if (r_state != S_IDLE && abort) begin
        r_state     <= S_IDLE;
        r_drive_low <= 1'b0;
        r_busy      <= 1'b0;
        r_rd_en     <= 1'b0;
        r_pend      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              if (w_len_ok) begin
                r_len     <= len;
                r_rd_en   <= 1'b1;
                r_rd_addr <= '0;
                r_busy    <= 1'b1;
                r_state   <= S_FETCH;
              end else begin
                r_len_err <= 1'b1;
              end
            end
          end

          S_FETCH: r_state <= S_LOAD;

          S_LOAD: begin
            r_shift     <= rd_data;
            r_div       <= '0;
            r_cell      <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_drive_low <= 1'b1;
            r_state     <= S_SEND;
          end

          S_SEND: begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (r_cell != 2'd3) begin
                r_cell      <= r_cell + 2'd1;
                // cells 1 and 2 carry the bit, cell 3 is always released
                r_drive_low <= (r_cell != 2'd2) && !r_shift[7];
              end else begin
                r_cell      <= '0;
                r_drive_low <= 1'b1;
                if (r_bit == 3'd7) begin
                  if (w_more_bytes) begin
                    r_shift <= r_hold;
                    r_byte  <= w_next_addr;
                    r_bit   <= '0;
                  end else begin
                    r_state <= S_STOP;
                  end
                end else begin
                  r_shift <= {r_shift[6:0], 1'b0};
                  r_bit   <= r_bit + 3'd1;
                  if (r_bit == 3'd6 && w_more_bytes) begin
                    r_rd_en   <= 1'b1;
                    r_rd_addr <= w_next_addr;
                  end
                end
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end

          S_STOP: begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (r_cell != 2'd3) begin
                r_cell      <= r_cell + 2'd1;
                r_drive_low <= (r_cell == 2'd0);
              end else begin
                r_cell      <= '0;
                r_drive_low <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= S_IDLE;
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/joybus_reply_tx.md
# joybus_reply_tx

Parametrised N64 Joybus reply serializer for the GC-to-N64 adapter. It replaces the fixed per-command reply frames with one engine that streams any reply length, 1 to MAX_BYTES bytes, from an external byte buffer. Replies include controller state, status/identity, pak read data and rumble acknowledge. Each payload bit is encoded as four 1 µs line cells, and the engine appends the controller stop bit. It sits between the command decoder / reply buffer and the open-drain line driver.

## Interface
- CLK_DIV, 47: clk cycles per line cell (1 µs); must be ≥ 2.
- MAX_BYTES, 33: largest reply payload in bytes (32 data + CRC).
- LEN_W, $clog2(MAX_BYTES+1): width of len.
- ADDR_W, $clog2(MAX_BYTES): width of rd_addr.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: request to send a reply; sampled only in IDLE.
- len, in, LEN_W: payload byte count; latched on an accepted start.
- abort, in, 1: terminates the frame immediately.
- rd_en, out, 1: one-cycle buffer read strobe.
- rd_addr, out, ADDR_W: byte address for the read; 0 is the first byte sent.
- rd_data, in, 8: read data, valid exactly 1 cycle after rd_en.
- drive_low, out, 1: 1 pulls the Joybus line low; 0 releases it (pull-up high).
- busy, out, 1: high from the cycle after an accepted start until the cycle done pulses.
- done, out, 1: 1-cycle pulse when the frame completes normally.
- len_err, out, 1: 1-cycle pulse when a start is rejected.

## Operation
- Reset values: drive_low=0, busy=0, done=0, len_err=0, rd_en=0, rd_addr=0. State is IDLE and the cell divider is cleared.
- States: IDLE → FETCH → LOAD → SEND → STOP → IDLE.
- IDLE, start=1, 1 ≤ len ≤ MAX_BYTES, abort=0:
  - latch len;
  - go to FETCH.
- IDLE, start=1 with len=0 or len>MAX_BYTES:
  - pulse len_err next cycle;
  - stay in IDLE, with no rd_en.
- FETCH (1 cycle): rd_en=1, rd_addr=0.
- LOAD (1 cycle): load rd_data into the shift register; clear the divider, bit counter and byte counter.
- SEND: bytes go out in address order, MSB first. Bit encoding, in cell order:
  - bit '0' is low, low, low, high;
  - bit '1' is low, high, high, high.
- Cell divider: counts 0..CLK_DIV-1 and advances the cell index on wrap. The cell index counts 0..3 per bit.
- Prefetch rule:
  - When cell 0 of bit 7 (the LSB) of byte k begins and k < len-1, pulse rd_en with rd_addr=k+1.
  - Capture rd_data into a holding register on the next cycle.
  - Transfer the holding register to the shift register at the byte boundary.
- Each address 0..len-1 is read exactly once, and no read occurs at or beyond len.
- STOP: four cells, low, low, high, high. Afterwards drive_low=0, busy falls, done pulses, and the state returns to IDLE.
- start while busy: ignored, with no len_err.
- abort=1 in any state other than IDLE: next cycle drive_low=0, busy=0, state IDLE, no done. A pending rd_en is cancelled.
- abort and start in the same IDLE cycle: abort wins and start is ignored.
- rst mid-frame behaves identically to abort. The line is released the following cycle.

## Timing
- Cycle numbering: start is accepted at cycle 0.
- rd_en is high in cycle 1; rd_data is captured at the end of cycle 2.
- drive_low first rises in cycle 3, which is the start of cell 0 of bit 0.
- Every cell lasts exactly CLK_DIV cycles, with no jitter between bits or bytes.
- Frame length: (32·len + 4)·CLK_DIV cycles from cycle 3.
- done pulses in cycle 3 + (32·len + 4)·CLK_DIV; busy is low in that same cycle.
- drive_low is registered, so there is no glitch between adjacent low cells.
- After done, the next start is accepted the following cycle.

## Test plan
- CLK_DIV=4, len=1, byte 0x80:
  - cells are 0111, then seven repetitions of 0001, then stop 0011 (listed as drive_low inverted);
  - drive_low rises at cycle 3;
  - done at cycle 147;
  - exactly one rd_en, at addr 0.
- len=3, bytes 0x05,0x00,0x02 (status reply): decoded line equals the bytes MSB first; rd_addr sequence is exactly 0,1,2; done at cycle 3+100·4=403.
- len=33 random pak data with a 1-cycle-latency model RAM: bit-exact decode, 33 reads, done at cycle 4243, no cell length other than 4 cycles.
- start with len=0, then with len=34: len_err pulses each time; rd_en, busy and drive_low stay 0.
- abort mid-byte 2 of a len=4 frame: drive_low=0 and busy=0 next cycle, no done. A following start (len=1, 0xFF) completes with correct timing.
- Error cases:
  - rst asserted mid-frame: all outputs return to reset values next cycle.
  - start re-pulsed while busy: no effect on the frame and no len_err.
  - start and abort together in IDLE: nothing is sent.
